// File: rtl/xalu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// counter width and default latencies.
package xalu_ctrl_pkg;

   typedef enum logic [2:0] {
      XOP_NONE  = 3'd0,
      XOP_MULT  = 3'd1,
      XOP_MULTU = 3'd2,
      XOP_DIV   = 3'd3,
      XOP_DIVU  = 3'd4,
      XOP_MTHI  = 3'd5,
      XOP_MTLO  = 3'd6,
      XOP_RSVD  = 3'd7
   } xalu_op_e;

   localparam int CNT_W           = 4;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Ops that occupy the unit for more than one cycle.
   function automatic logic is_start_op(xalu_op_e op);
      return (op == XOP_MULT) || (op == XOP_MULTU) ||
             (op == XOP_DIV)  || (op == XOP_DIVU);
   endfunction

endpackage

// File: rtl/xalu_ctrl_if.sv
// Pipeline-side bundle of the XALU: E-stage request, D-stage use flag,
// HI/LO results and the busy/stall status.
interface xalu_ctrl_if;

   logic [2:0]  XALU_Op_E;
   logic [31:0] A_E;
   logic [31:0] B_E;
   logic        XALU_Use_D;
   logic [31:0] XALU_HI;
   logic [31:0] XALU_LO;
   logic        Busy;
   logic        Start;
   logic        XALU_Stall;

   modport master (
      output XALU_Op_E, A_E, B_E, XALU_Use_D,
      input  XALU_HI, XALU_LO, Busy, Start, XALU_Stall
   );

   modport slave (
      input  XALU_Op_E, A_E, B_E, XALU_Use_D,
      output XALU_HI, XALU_LO, Busy, Start, XALU_Stall
   );

endinterface

// File: rtl/xalu_busy_cnt.sv
// Loadable down-counter: busy while non-zero, done on the cycle whose
// closing edge takes it from 1 to 0.
module xalu_busy_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         busy,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign busy = (cnt_q != '0);
   assign done = (cnt_q == W'(1));

endmodule

// File: rtl/xalu_ctrl.sv
// XALU sequencer: computes the result at issue, holds it pending for the
// modelled latency, then commits it to HI/LO.
module xalu_ctrl
   import xalu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input logic         clk,
   input logic         reset,
   xalu_ctrl_if.slave  xbus
);

   xalu_op_e        op;
   logic [31:0]     a, b;
   logic            start, busy, done, issue, is_mult;
   logic [CNT_W-1:0] load_val;

   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic        pend_wr_q, pend_wr_d;

   logic [63:0] prod;
   logic [31:0] quo, rem;

   assign op       = xalu_op_e'(xbus.XALU_Op_E);
   assign a        = xbus.A_E;
   assign b        = xbus.B_E;
   assign start    = is_start_op(op);
   assign issue    = start && !busy;
   assign is_mult  = (op == XOP_MULT) || (op == XOP_MULTU);
   assign load_val = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

   xalu_busy_cnt #(.W(CNT_W)) u_busy_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (issue),
      .load_val (load_val),
      .busy     (busy),
      .done     (done)
   );

   // Sign-extending to 64 bits makes the low 64 bits of the product correct for mult.
   always_comb begin
      if (op == XOP_MULT)
         prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else
         prod = {32'b0, a} * {32'b0, b};

      quo = '0;
      rem = '0;
      if (b != '0) begin
         if (op == XOP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               quo = a;
               rem = '0;
            end else begin
               quo = $signed(a) / $signed(b);
               rem = $signed(a) % $signed(b);
            end
         end else begin
            quo = a / b;
            rem = a % b;
         end
      end
   end

   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;

      if (issue) begin
         pend_hi_d = is_mult ? prod[63:32] : rem;
         pend_lo_d = is_mult ? prod[31:0]  : quo;
         pend_wr_d = is_mult || (b != '0);
      end

      // Divide by zero leaves HI/LO untouched at completion.
      if (done && pend_wr_q) begin
         hi_d = pend_hi_q;
         lo_d = pend_lo_q;
      end

      if (!busy && op == XOP_MTHI) hi_d = a;
      if (!busy && op == XOP_MTLO) lo_d = a;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign xbus.XALU_HI    = hi_q;
   assign xbus.XALU_LO    = lo_q;
   assign xbus.Busy       = busy;
   assign xbus.Start      = start;
   assign xbus.XALU_Stall = xbus.XALU_Use_D && (start || busy);

endmodule

// File: tb/tb_xalu_ctrl.sv
// Directed-vector bench for xalu_ctrl with hand-computed HI/LO, Busy and
// Stall expectations cycle by cycle.
module tb_xalu_ctrl;
   import xalu_ctrl_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   xalu_ctrl_if xbus();

   xalu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .xbus  (xbus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] mdl_hi = '0;
   logic [31:0] mdl_lo = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // The unit must never see a new op while one is in flight.
   always @(negedge clk) begin
      if (!reset && xbus.Start && xbus.Busy) begin
         n_err++;
         $display("FAIL issue_while_busy: Start and Busy both high at %0t", $time);
      end
   end

   // Presents one op in cycle T, then walks T+1..T+n+1 checking Busy,
   // Stall and that HI/LO only change after the last busy cycle.
   task automatic run_op(input string tag, input xalu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic use_d,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      logic st;
      st = (op == XOP_MULT) || (op == XOP_MULTU) || (op == XOP_DIV) || (op == XOP_DIVU);
      xbus.XALU_Op_E  = op;
      xbus.A_E        = a;
      xbus.B_E        = b;
      xbus.XALU_Use_D = use_d;
      #1;
      check({tag, ":start"},  32'(xbus.Start),      32'(st));
      check({tag, ":stall0"}, 32'(xbus.XALU_Stall), 32'(use_d & st));
      check({tag, ":busy0"},  32'(xbus.Busy),       32'd0);
      next_cycle();
      xbus.XALU_Op_E = XOP_NONE;
      xbus.A_E       = 32'hDEAD_BEEF;
      xbus.B_E       = 32'h0BAD_F00D;
      #1;
      for (int i = 1; i <= n; i++) begin
         check({tag, ":busy"},  32'(xbus.Busy),       32'd1);
         check({tag, ":stall"}, 32'(xbus.XALU_Stall), 32'(use_d));
         check({tag, ":hi_old"}, xbus.XALU_HI, mdl_hi);
         check({tag, ":lo_old"}, xbus.XALU_LO, mdl_lo);
         next_cycle();
      end
      mdl_hi = exp_hi;
      mdl_lo = exp_lo;
      check({tag, ":busy_end"},  32'(xbus.Busy),       32'd0);
      check({tag, ":stall_end"}, 32'(xbus.XALU_Stall), 32'd0);
      check({tag, ":hi"}, xbus.XALU_HI, mdl_hi);
      check({tag, ":lo"}, xbus.XALU_LO, mdl_lo);
   endtask

   initial begin
      xbus.XALU_Op_E  = XOP_NONE;
      xbus.A_E        = '0;
      xbus.B_E        = '0;
      xbus.XALU_Use_D = 1'b0;
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      check("rst:hi",   xbus.XALU_HI, 32'h0);
      check("rst:lo",   xbus.XALU_LO, 32'h0);
      check("rst:busy", 32'(xbus.Busy), 32'd0);
      check("rst:stall", 32'(xbus.XALU_Stall), 32'd0);

      // 1. mult / multu
      run_op("mult",  XOP_MULT,  32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu", XOP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);

      // 2. div / divu, plus sign-of-remainder and overflow corners
      run_op("div",    XOP_DIV,  32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu",   XOP_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC);
      run_op("div_np", XOP_DIV,  32'd7, 32'hFFFF_FFFE, 10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("div_ov", XOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'h0, 32'h8000_0000);

      // 3. mthi then mtlo in consecutive cycles
      run_op("mthi", XOP_MTHI, 32'h1234_5678, 32'h0, 0, 1'b0, 32'h1234_5678, mdl_lo);
      run_op("mtlo", XOP_MTLO, 32'h9ABC_DEF0, 32'h0, 0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);

      // 4. Stall with and without a D-stage XALU user
      run_op("stall_mult", XOP_MULT, 32'd3, 32'd4, 5, 1'b1, 32'h0, 32'd12);
      xbus.XALU_Use_D = 1'b0;
      run_op("nostall_mult", XOP_MULTU, 32'h0001_0000, 32'h0001_0000, 5, 1'b0, 32'h1, 32'h0);

      // 5. Divide by zero keeps preloaded HI/LO
      run_op("pre_hi", XOP_MTHI, 32'h55, 32'h0, 0, 1'b0, 32'h55, mdl_lo);
      run_op("pre_lo", XOP_MTLO, 32'h55, 32'h0, 0, 1'b0, 32'h55, 32'h55);
      run_op("divu0", XOP_DIVU, 32'h1234, 32'h0, 10, 1'b0, 32'h55, 32'h55);
      run_op("div0",  XOP_DIV,  32'h1234, 32'h0, 10, 1'b0, 32'h55, 32'h55);

      // 6. Reset at T+3 of a div aborts it with no late write
      xbus.XALU_Op_E = XOP_DIV;
      xbus.A_E       = 32'd100;
      xbus.B_E       = 32'd7;
      next_cycle();
      xbus.XALU_Op_E = XOP_NONE;
      next_cycle();
      next_cycle();
      reset = 1'b1;
      next_cycle();
      check("abort:busy", 32'(xbus.Busy), 32'd0);
      check("abort:hi", xbus.XALU_HI, 32'h0);
      check("abort:lo", xbus.XALU_LO, 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         check("abort:late_busy", 32'(xbus.Busy), 32'd0);
         check("abort:late_hi", xbus.XALU_HI, 32'h0);
         check("abort:late_lo", xbus.XALU_LO, 32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xalu_ctrl.md
Name: xalu_ctrl

Overview:
- Sequencer and result holder for the pipeline's multiply/divide unit (XALU).
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and latches operands on issue.
- Models the multi-cycle latency with a busy counter and owns the HI/LO registers that feed XALU__MUX.
- Produces the stall request that freezes F/D when a decode-stage instruction needs the XALU while it is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (must be 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- XALU_Op_E  in  3  E-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- A_E  in  32  forwarded rs value.
- B_E  in  32  forwarded rt value.
- XALU_Use_D  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- XALU_HI  out  32  HI register.
- XALU_LO  out  32  LO register.
- Busy  out  1  operation in flight.
- Start  out  1  combinational: XALU_Op_E is mult/multu/div/divu.
- XALU_Stall  out  1  combinational: XALU_Use_D & (Start | Busy).

Behaviour:
- Synchronous active-high reset, applied on clk edge. Takes priority over everything.
- Reset values: HI=0, LO=0, counter=0, Busy=0, pending result=0.
- Reset mid-operation aborts the operation; the pending result is discarded.
- Issue (cycle T, Start=1, Busy=0):
  - mult/multu: latch the 64-bit product of A_E×B_E into the pending register. Signed for mult, unsigned for multu. {hi,lo} = product[63:32], product[31:0].
  - div/divu: pending lo = quotient, hi = remainder. Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
- Counting:
  - Busy = (counter != 0). Busy is high in cycles T+1 .. T+N.
  - Counter decrements once per cycle.
  - On the edge where counter goes 1→0, HI/LO ← pending. New values are visible from T+N+1, when Busy is already 0.
- Divide by zero (B_E==0 on div/divu): the full busy sequence still runs. HI/LO are left unchanged at completion.
- Signed overflow on div (0x80000000 / -1): LO=0x80000000, HI=0.
- mthi/mtlo (Busy=0): HI or LO ← A_E at the end of cycle T. Single cycle, no Busy.
- Op arriving while Busy=1: ignored and the counter is not disturbed.
  - This is a protocol violation, since XALU_Stall prevents it. The bench asserts that it never occurs.
- Start and XALU_Use_D in the same cycle: Stall=1 that cycle, which covers back-to-back mult/mfhi.
- mfhi/mflo reads XALU_HI/XALU_LO combinationally in E once the stall releases.
- No internal bypass of pending values.
- Counter width: 4 bits.

Decomposition:
- Shared package/header holds:
  - XALU_Op encodings (XOP_NONE, XOP_MULT, XOP_MULTU, XOP_DIV, XOP_DIVU, XOP_MTHI, XOP_MTLO).
  - MULT_CYCLES/DIV_CYCLES defaults.
- One natural sub-module, xalu_busy_cnt: a loadable down-counter with a done pulse. Arithmetic stays inline.

Test Plan:
1. Reset, then mult A=0xFFFFFFFF, B=2 at T → Busy high T+1..T+5. From T+6, HI=0xFFFFFFFF and LO=0xFFFFFFFE. With multu on the same operands, HI=0x00000001 and LO=0xFFFFFFFE.
2. div A=-7 (0xFFFFFFF9), B=2 → Busy for 10 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1). With divu on the same operands, LO=0x7FFFFFFC and HI=1.
3. mthi A=0x12345678, then mtlo A=0x9ABCDEF0 in consecutive cycles → HI=0x12345678 and LO=0x9ABCDEF0 one cycle after each; Busy stays 0.
4. Issue mult with XALU_Use_D=1 held → XALU_Stall=1 in cycles T..T+5 and 0 at T+6. With XALU_Use_D=0, XALU_Stall stays 0 throughout.
5. Preload HI=LO=0x55, then divu B=0 → Busy for 10 cycles; HI/LO remain 0x55.
6. Assert reset at T+3 of a div → next cycle Busy=0 and HI=LO=0. No late write occurs at T+10.
